// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and receive FIFO.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x byte storage for the UART receive FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  uart_byte_t               wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output uart_byte_t               rdata_c
);

   uart_byte_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with sticky overflow flag.
// Define UART_RX_FIFO_LEVEL_EN to add the occupancy output port "level".
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   button_rst,
   input  uart_byte_t             rx_data,
   input  logic                   rx_valid,
   output uart_byte_t             rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic                   full,
   output logic                   overflow,
   input  logic                   ovf_clr
`ifdef UART_RX_FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] level
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   uart_byte_t    rd_data_q, rd_data_d;
   logic          rd_valid_q, full_q, overflow_q, overflow_d;
   logic          pop, wr_en;
   uart_byte_t    ram_rdata;

   assign pop   = rd_valid_q & rd_ready;
   assign wr_en = rx_valid & (~full_q | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      overflow_d = overflow_q & ~ovf_clr;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Set wins over clear.
      if (rx_valid && full_q && !pop) begin
         overflow_d = 1'b1;
      end

      // Next head: bypass the incoming byte when it lands in an empty slot chain.
      if (wr_en && (count_q == CW'(pop))) begin
         rd_data_d = rx_data;
      end else if (count_d != '0) begin
         rd_data_d = ram_rdata;
      end
   end

   always_ff @(posedge clk or negedge button_rst) begin
      if (!button_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= (count_d != '0);
         full_q     <= (count_d == CW'(DEPTH));
         overflow_q <= overflow_d;
      end
   end

   uart_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (rx_data),
      .raddr_i (rd_ptr_d),
      .rdata_c (ram_rdata)
   );

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign full     = full_q;
   assign overflow = overflow_q;

`ifdef UART_RX_FIFO_LEVEL_EN
   assign level = count_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes, a monitor
// compares every pop; flags are checked directly after the relevant edge.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       button_rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       full;
   logic       overflow;
   logic       ovf_clr;
`ifdef UART_RX_FIFO_LEVEL_EN
   logic [4:0] level;
`endif

   int n_pass  = 0;
   int n_total = 0;
   logic [7:0] sb_q [$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(16)) dut (
      .clk        (clk),
      .button_rst (button_rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .full       (full),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
`ifdef UART_RX_FIFO_LEVEL_EN
      ,
      .level      (level)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
   endtask

   // Pop monitor: a pop happens at the next rising edge when both are high now.
   always @(negedge clk) begin
      if (button_rst === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL pop_unexpected got=%0h exp=none at %0t", rd_data, $time);
         end else begin
            check("pop_data", {24'h0, rd_data}, {24'h0, sb_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b, input bit push);
      rx_valid = 1'b1;
      rx_data  = b;
      if (push) sb_q.push_back(b);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      rd_ready = 1'b1;
      while (rd_valid && guard < 40) begin
         tick();
         guard++;
      end
      check(name, {31'h0, rd_valid}, 32'h0);
      check({name, "_sb_empty"}, sb_q.size(), 0);
      rd_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      button_rst = 1'b0;
      rx_data    = 8'h00;
      rx_valid   = 1'b0;
      rd_ready   = 1'b0;
      ovf_clr    = 1'b0;
      #2;
      check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
      check("rst_full",     {31'h0, full},     32'h0);
      check("rst_overflow", {31'h0, overflow}, 32'h0);
      check("rst_rd_data",  {24'h0, rd_data},  32'h0);
      tick();
      tick();
      button_rst = 1'b1;
      tick();

      // Basic order with 1-cycle show-ahead latency.
      wr(8'h56, 1'b1);
      check("first_rd_valid", {31'h0, rd_valid}, 32'h1);
      check("first_rd_data",  {24'h0, rd_data},  32'h56);
      wr(8'hA5, 1'b1);
      wr(8'h3C, 1'b1);
      tick();
      check("hold_rd_data", {24'h0, rd_data}, 32'h56);
      drain("basic_drain");

      // Fill to full, then overflow.
      for (int i = 0; i < 16; i++) wr(8'(i), 1'b1);
      check("full_set",   {31'h0, full},     32'h1);
      check("full_noovf", {31'h0, overflow}, 32'h0);
`ifdef UART_RX_FIFO_LEVEL_EN
      check("level_full", {27'h0, level}, 32'd16);
`endif
      wr(8'hFF, 1'b0);
      check("ovf_set",       {31'h0, overflow}, 32'h1);
      check("ovf_full_kept", {31'h0, full},     32'h1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", {31'h0, overflow}, 32'h0);
      ovf_clr = 1'b1;
      wr(8'hFE, 1'b0);
      ovf_clr = 1'b0;
      check("ovf_set_prio", {31'h0, overflow}, 32'h1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr2", {31'h0, overflow}, 32'h0);

      // Write and pop together while full.
      rd_ready = 1'b1;
      wr(8'h77, 1'b1);
      rd_ready = 1'b0;
      check("wp_full_noovf", {31'h0, overflow}, 32'h0);
      check("wp_full_full",  {31'h0, full},     32'h1);
      drain("full_drain");

      // Write and pop together at count 1.
      wr(8'h11, 1'b1);
      rd_ready = 1'b1;
      wr(8'h22, 1'b1);
      check("c1_rd_valid", {31'h0, rd_valid}, 32'h1);
      check("c1_rd_data",  {24'h0, rd_data},  32'h22);
      tick();
      rd_ready = 1'b0;
      check("c1_empty", {31'h0, rd_valid}, 32'h0);

      // rd_ready while empty must not underflow.
      rd_ready = 1'b1;
      tick();
      tick();
      tick();
      check("uf_rd_valid", {31'h0, rd_valid}, 32'h0);
      rd_ready = 1'b0;
      wr(8'h33, 1'b1);
      check("uf_rd_data", {24'h0, rd_data}, 32'h33);
      check("uf_full",    {31'h0, full},    32'h0);
      drain("uf_drain");

      // 40 write/pop pairs across pointer wrap.
      rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) wr(8'(8'h40 + i), 1'b1);
      drain("wrap_drain");

      // Reset mid-cycle discards contents.
      wr(8'hC1, 1'b0);
      wr(8'hC2, 1'b0);
      wr(8'hC3, 1'b0);
      check("pre_rst_rd_data", {24'h0, rd_data}, 32'hC1);
      #2;
      button_rst = 1'b0;
      rx_valid   = 1'b1;
      rx_data    = 8'hEE;
      #1;
      check("mid_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
      check("mid_rst_rd_data",  {24'h0, rd_data},  32'h0);
      check("mid_rst_full",     {31'h0, full},     32'h0);
`ifdef UART_RX_FIFO_LEVEL_EN
      check("mid_rst_level", {27'h0, level}, 32'h0);
`endif
      tick();
      rx_valid   = 1'b0;
      check("in_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
      button_rst = 1'b1;
      tick();
      tick();
      check("post_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
      check("final_sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving FIFO capacity in bytes; it must be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port button_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-005 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port rd_data, output, 8 bits: head-of-FIFO byte, meaningful only while rd_valid is 1.
REQ-007 SHALL have port rd_valid, output, 1 bit: FIFO is non-empty and rd_data is valid.
REQ-008 SHALL have port rd_ready, input, 1 bit: consumer accepts rd_data.
REQ-009 SHALL have port full, output, 1 bit: occupancy equals DEPTH.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag indicating a received byte was dropped.
REQ-011 SHALL have port ovf_clr, input, 1 bit: synchronous clear of overflow.

Function
REQ-012 SHALL accept a write when rx_valid=1 and either full=0 or a pop occurs in the same cycle.
REQ-013 SHALL define a pop as rd_valid=1 and rd_ready=1 in the same cycle; pop advances the head by one.
REQ-014 SHALL be show-ahead: a byte written into an empty FIFO appears on rd_data with rd_valid=1 on the next cycle (1-cycle latency).
REQ-015 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-016 SHALL preserve byte order strictly (FIFO); the write and read pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-017 SHALL track occupancy in a log2(DEPTH)+1 bit count: write only → +1; pop only → -1; both or neither → unchanged.
REQ-018 SHALL drop rx_data and set overflow=1 on the next edge when rx_valid=1, full=1 and no pop occurs; FIFO contents stay unchanged.
REQ-019 SHALL give set priority: when overflow is being set in the same cycle ovf_clr=1, overflow ends up 1.
REQ-020 SHALL make simultaneous write and pop at count=DEPTH legal: the byte is accepted, full stays 1 and overflow is not set.
REQ-021 SHALL make simultaneous write and pop at count=1 legal: rd_valid stays 1 and rd_data shows the new byte the next cycle.
REQ-022 SHALL ignore rd_ready while rd_valid=0; there is no underflow and the pointers do not move.
REQ-023 SHALL drive full and rd_valid as registered outputs derived from the count; neither has a combinational path from an input.

Reset
REQ-024 SHALL, while button_rst=0, immediately force rd_valid=0, full=0, overflow=0, rd_data=8'h00, count=0 and both pointers=0.
REQ-025 SHALL discard all stored bytes on a reset asserted mid-operation; rx_valid is ignored while reset is asserted.
REQ-026 SHALL not require the storage array contents to be reset.

Configuration
REQ-027 SHALL compile in, when macro UART_RX_FIFO_LEVEL_EN is defined, an extra output port level (log2(DEPTH)+1 bits) equal to the registered occupancy count, reset value 0.
REQ-028 SHALL, without UART_RX_FIFO_LEVEL_EN, omit the level port, with all other behaviour identical.

Structure
REQ-029 SHALL take constant UART_DATA_W=8 and typedef uart_byte_t from the shared package uart_pkg, which is also used by the UART receiver and transmitter.
REQ-030 SHALL place storage in sub-module uart_fifo_ram: DEPTH x 8 bits, one synchronous write port, one read port addressed by the read pointer.

Verification
REQ-031 SHALL verify basic order: after reset, write 8'h56, 8'hA5, 8'h3C with rd_ready=0 → rd_valid=1 one cycle after the first write, rd_data=8'h56; raise rd_ready → pops yield 56, A5, 3C in that order, then rd_valid=0.
REQ-032 SHALL verify full/overflow: with DEPTH=16, write 16 bytes 8'h00..8'h0F → full=1; write 8'hFF → overflow=1, and 16 pops return 00..0F with no FF.
REQ-033 SHALL verify simultaneous write+pop: when full, write 8'h77 with a pop in the same cycle → overflow stays 0, full stays 1, and 8'h77 is the last byte read.
REQ-034 SHALL verify clear vs set: with overflow=1, pulse ovf_clr → 0; with full=1, apply rx_valid and ovf_clr together → overflow=1.
REQ-035 SHALL verify wrap and reset: perform 40 write/pop pairs with incrementing data → readback matches exactly; then write 3 bytes and assert button_rst mid-cycle → rd_valid=0 immediately and level=0 (LEVEL_EN build).
